ff_override_ctrl: RTL and testbench

FF_OVERRIDE_CTRL -- requirements
Module: ff_override_ctrl

---
 rtl/ff_override_ctrl_pkg.sv | 19 +
 rtl/ff_override_ctrl_if.sv | 30 +++
 rtl/ff_override_ctrl_rr_arbiter.sv | 29 ++
 rtl/ff_override_ctrl.sv | 118 +++++++++++
 tb/tb_ff_override_ctrl.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/ff_override_ctrl_pkg.sv
// Shared constants for the force/override controller: opcodes, FSM encoding, size defaults.
package ff_override_ctrl_pkg;

    localparam int unsigned NREQ_DEFAULT = 3;
    localparam int unsigned W_DEFAULT    = 8;

    localparam logic [1:0] OP_LOAD    = 2'b00;
    localparam logic [1:0] OP_PRESET  = 2'b01;
    localparam logic [1:0] OP_CLEAR   = 2'b10;
    localparam logic [1:0] OP_RELEASE = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StApply = 2'd2,
        StAck   = 2'd3
    } state_e;

endpackage

// File: rtl/ff_override_ctrl_if.sv
// Requester-side bundle of the override controller: per-requester request slices plus bank status.
interface ff_override_ctrl_if
    import ff_override_ctrl_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT,
    parameter int unsigned W    = W_DEFAULT
) ();

    logic [NREQ-1:0]   req;
    logic [2*NREQ-1:0] op;
    logic [W*NREQ-1:0] mask;
    logic [W*NREQ-1:0] data;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic              busy;
    logic [W-1:0]      q;
    logic [W-1:0]      set_mask;
    logic [W-1:0]      clr_mask;

    modport master (
        output req, op, mask, data,
        input  gnt, ack, busy, q, set_mask, clr_mask
    );

    modport slave (
        input  req, op, mask, data,
        output gnt, ack, busy, q, set_mask, clr_mask
    );

endinterface

// File: rtl/ff_override_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first active request at or after the pointer wins.
module rr_arbiter
    import ff_override_ctrl_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT,
    parameter int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PtrW-1:0] ptr,
    output logic [NREQ-1:0] winner
);

    int unsigned idx;
    logic        found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ff_override_ctrl.sv
// Arbitrated controller for a register bank with per-bit preset/clear overrides.
module ff_override_ctrl
    import ff_override_ctrl_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT,
    parameter int unsigned W    = W_DEFAULT
) (
    input logic               clk,
    input logic               clr,
    ff_override_ctrl_if.slave bus
);

    localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          state_q, state_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] win_idx;
    logic [NREQ-1:0] win, win_q;
    logic [1:0]      op_q;
    logic [W-1:0]    mask_q, data_q;
    logic [W-1:0]    q_reg, set_q, clr_q;
    logic [W-1:0]    q_reg_d, set_d, clr_d;
    logic [W-1:0]    q_eff;
    logic            take;

    rr_arbiter #(
        .NREQ (NREQ),
        .PtrW (PtrW)
    ) u_arb (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (win)
    );

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win[i]) win_idx = PtrW'(i);
        end
        ptr_d = (32'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
    end

    assign take = (state_q == StIdle) && (|bus.req);

    // State register
    always_ff @(posedge clk) begin
        if (!clr) state_q <= StIdle;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (take) state_d = StGrant;
            StGrant: state_d = StApply;
            StApply: state_d = StAck;
            StAck:   state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        bus.gnt  = (state_q == StGrant) ? win_q : '0;
        bus.ack  = (state_q == StAck) ? win_q : '0;
        bus.busy = (state_q != StIdle);
    end

    // Clear beats preset beats the stored value.
    assign q_eff        = ~clr_q & (set_q | q_reg);
    assign bus.q        = q_eff;
    assign bus.set_mask = set_q;
    assign bus.clr_mask = clr_q;

    always_comb begin
        q_reg_d = q_reg;
        set_d   = set_q;
        clr_d   = clr_q;
        unique case (op_q)
            OP_LOAD:    q_reg_d = (q_reg & ~mask_q) | (data_q & mask_q);
            OP_PRESET:  set_d   = set_q | mask_q;
            OP_CLEAR:   clr_d   = clr_q | mask_q;
            OP_RELEASE: begin
                // Freeze the forced value into the register so q is unchanged.
                q_reg_d = (q_reg & ~mask_q) | (q_eff & mask_q);
                set_d   = set_q & ~mask_q;
                clr_d   = clr_q & ~mask_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            ptr_q  <= '0;
            win_q  <= '0;
            op_q   <= OP_LOAD;
            mask_q <= '0;
            data_q <= '0;
            q_reg  <= '0;
            set_q  <= '0;
            clr_q  <= '0;
        end else begin
            if (take) begin
                ptr_q  <= ptr_d;
                win_q  <= win;
                op_q   <= bus.op[2*32'(win_idx) +: 2];
                mask_q <= bus.mask[W*32'(win_idx) +: W];
                data_q <= bus.data[W*32'(win_idx) +: W];
            end
            if (state_q == StApply) begin
                q_reg <= q_reg_d;
                set_q <= set_d;
                clr_q <= clr_d;
            end
        end
    end

endmodule

// File: tb/tb_ff_override_ctrl.sv
// Directed bench for ff_override_ctrl: handshake timing, round-robin order, override semantics, reset abort.
module tb_ff_override_ctrl;
    import ff_override_ctrl_pkg::*;

    localparam int unsigned NREQ = 3;
    localparam int unsigned W    = 8;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   errors = 0;
    int   checks = 0;

    ff_override_ctrl_if #(.NREQ(NREQ), .W(W)) bus ();

    ff_override_ctrl #(
        .NREQ (NREQ),
        .W    (W)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int r, input logic [1:0] o, input logic [7:0] m,
                         input logic [7:0] d);
        bus.op[2*r +: 2]   = o;
        bus.mask[W*r +: W] = m;
        bus.data[W*r +: W] = d;
    endtask

    // One full handshake from an idle controller; inputs are scrambled after grant.
    task automatic txn(input int r, input logic [1:0] o, input logic [7:0] m,
                       input logic [7:0] d, input bit drop_early);
        @(negedge clk);
        drive(r, o, m, d);
        bus.req[r] = 1'b1;
        @(negedge clk);
        chk("gnt", 32'(bus.gnt), 32'(1) << r);
        chk("busy_grant", 32'(bus.busy), 32'd1);
        drive(r, ~o, ~m, ~d);
        if (drop_early) bus.req[r] = 1'b0;
        @(negedge clk);
        chk("apply_quiet", {bus.gnt, bus.ack}, 32'd0);
        @(negedge clk);
        chk("ack", 32'(bus.ack), 32'(1) << r);
        bus.req[r] = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req  = '1;
        bus.op   = '0;
        bus.mask = '0;
        bus.data = '0;
        clr      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_q", 32'(bus.q), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_set", 32'(bus.set_mask), 32'd0);
        chk("rst_clr", 32'(bus.clr_mask), 32'd0);

        // All three requesting with zero masks: order 0,1,2,0 every 4 cycles.
        clr = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            chk("rr_gnt", 32'(bus.gnt), (c % 4 == 1) ? (32'(1) << ((c / 4) % 3)) : 32'd0);
            chk("rr_ack", 32'(bus.ack), (c % 4 == 3) ? (32'(1) << ((c / 4) % 3)) : 32'd0);
        end
        bus.req = '0;
        repeat (3) @(negedge clk);
        chk("rr_idle", 32'(bus.busy), 32'd0);
        chk("rr_q", 32'(bus.q), 32'd0);

        txn(0, OP_LOAD, 8'hFF, 8'hA5, 1'b0);
        chk("load_q", 32'(bus.q), 32'hA5);
        txn(1, OP_PRESET, 8'h0F, 8'h00, 1'b0);
        chk("preset_q", 32'(bus.q), 32'hAF);
        chk("preset_set", 32'(bus.set_mask), 32'h0F);
        txn(2, OP_CLEAR, 8'h03, 8'h00, 1'b0);
        chk("clear_q", 32'(bus.q), 32'hAC);
        chk("clear_clr", 32'(bus.clr_mask), 32'h03);
        txn(0, OP_RELEASE, 8'hFF, 8'h00, 1'b0);
        chk("rel_q", 32'(bus.q), 32'hAC);
        chk("rel_set", 32'(bus.set_mask), 32'h00);
        chk("rel_clr", 32'(bus.clr_mask), 32'h00);
        txn(1, OP_LOAD, 8'h00, 8'h55, 1'b0);
        chk("zero_mask_q", 32'(bus.q), 32'hAC);
        txn(2, OP_LOAD, 8'hF0, 8'h00, 1'b1);
        chk("drop_q", 32'(bus.q), 32'h0C);

        // Reset during APPLY aborts the load.
        @(negedge clk);
        drive(1, OP_LOAD, 8'hFF, 8'h3C);
        bus.req[1] = 1'b1;
        @(negedge clk);
        chk("abort_gnt", 32'(bus.gnt), 32'h2);
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 32'd1);
        clr     = 1'b0;
        bus.req = '0;
        @(negedge clk);
        chk("abort_ack", 32'(bus.ack), 32'd0);
        chk("abort_idle", 32'(bus.busy), 32'd0);
        chk("abort_q", 32'(bus.q), 32'd0);
        clr = 1'b1;
        @(negedge clk);
        chk("abort_ack2", 32'(bus.ack), 32'd0);
        chk("abort_q2", 32'(bus.q), 32'd0);

        // Loads under a clear override stay hidden until released.
        txn(0, OP_CLEAR, 8'hF0, 8'h00, 1'b0);
        chk("ovr_q0", 32'(bus.q), 32'h00);
        txn(0, OP_LOAD, 8'hFF, 8'hFF, 1'b0);
        chk("ovr_q1", 32'(bus.q), 32'h0F);
        txn(0, OP_RELEASE, 8'hFF, 8'h00, 1'b0);
        chk("ovr_rel_q", 32'(bus.q), 32'h0F);
        chk("ovr_rel_clr", 32'(bus.clr_mask), 32'h00);
        txn(0, OP_LOAD, 8'hFF, 8'hFF, 1'b0);
        chk("ovr_load_q", 32'(bus.q), 32'hFF);

        // Clear beats preset; release keeps the forced 0 even though q_reg holds 1.
        txn(1, OP_CLEAR, 8'h01, 8'h00, 1'b0);
        chk("cw_clear_q", 32'(bus.q), 32'hFE);
        txn(2, OP_PRESET, 8'h01, 8'h00, 1'b0);
        chk("cw_preset_q", 32'(bus.q), 32'hFE);
        txn(0, OP_RELEASE, 8'h01, 8'h00, 1'b0);
        chk("cw_rel_q", 32'(bus.q), 32'hFE);
        chk("cw_rel_set", 32'(bus.set_mask), 32'h00);
        txn(1, OP_PRESET, 8'h01, 8'h00, 1'b0);
        chk("cw_preset2_q", 32'(bus.q), 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
